mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  Memory-access stage of the 5-stage pipeline, between execute and write-back.
//  Registers the execute->memory bus under stall control and takes the synchronous
//  data-SRAM read data; the address was issued in the previous (execute) cycle.
//  Sign/zero-extends load data and selects between load data and ALU result.
//  Drives the write-back bus plus a forwarding bus back to decode.
// PARAMETERS
//  EX_TO_MEM_WD   79  width of ex_to_mem_bus
//  MEM_TO_WB_WD   70  width of mem_to_wb_bus
//  MEM_TO_RF_WD   38  width of mem_to_rf_bus (forwarding)
// PORTS
//  clk             in   1    clock
//  rst             in   1    synchronous, active-high reset
//  stall           in   6    pipeline stall bus; [3]=MEM stop, [4]=WB stop (1=Stop)
//  ex_to_mem_bus   in   79   {pc[78:47], ram_en[46], ram_wen[45:42], load_op[41:39],
//                            sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}
//  data_sram_rdata in   32   SRAM read data for the address issued last cycle
//  mem_to_wb_bus   out  70   {pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}
//  mem_to_rf_bus   out  38   {rf_we[37], rf_waddr[36:32], rf_wdata[31:0]} (to decode)
// BEHAVIOUR
//  Pipeline register ex_to_mem_bus_r, priority order on posedge clk:
//   - rst: all zero
//   - stall[3]=Stop & stall[4]=NoStop: load all zero (bubble)
//   - stall[3]=NoStop: load ex_to_mem_bus
//   - otherwise: hold
//  A zero register is a NOP: rf_we=0, so no write-back and no forwarding hit.
//  Load = ram_en=1 & ram_wen=4'b0000. load_op encoding:
//   001 LB, 010 LBU, 011 LH, 100 LHU, 101 LW; 000/110/111 = no load, treated as LW.
//  Read-data hold: SRAM output is valid only in the first cycle after the load enters.
//   - if stall[3]=Stop in that cycle: capture data_sram_rdata into rdata_hold and
//     set hold_valid
//   - while hold_valid=1: use rdata_hold, else use data_sram_rdata
//   - hold_valid clears on rst, on bubble insertion, and when the register loads
//     new contents
//   - back-to-back loads without stall never use the hold path
//  Lane select uses addr = ex_result[1:0]:
//   - byte: lane addr (bits [8*addr+7 : 8*addr])
//   - half: addr[1]=0 -> [15:0], addr[1]=1 -> [31:16]; addr[0] is ignored
//     (misalignment is trapped upstream)
//   - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes all 32 bits
//  rf_wdata = sel_rf_res ? load_data : ex_result.
//  Stores (wen!=0) and ALU ops pass ex_result through; no SRAM dependency.
//  Outputs are combinational from the register, the hold logic and rdata.
//  Latency: one cycle from ex_to_mem_bus to mem_to_wb_bus.
//  After reset, both output buses read all zero.
//  Reset mid-stall: register and hold_valid clear in the same cycle.
// TESTING
//  1 ALU: bus {pc=0xBFC00010, rf_we=1, waddr=5, sel=0, ex_result=0x1234}, no stall
//    -> next cycle wb rf_wdata=0x1234, waddr=5; rf bus identical
//  2 LB, addr 0x...03, rdata=0x80FF0011 -> 0xFFFFFF80; LBU -> 0x00000080;
//    LH, addr 0x...02 -> 0xFFFF80FF; LHU -> 0x000080FF; LW -> 0x80FF0011
//  3 Load with stall[3]=1 for 3 cycles, rdata changes to 0xDEADBEEF after cycle 1
//    -> rf_wdata keeps the first-cycle value throughout
//  4 stall=6'b001111 (MEM stop, WB go) -> next cycle both output buses all zero
//  5 stall=6'b011111 (MEM and WB stop) -> register holds, outputs unchanged
//  6 rst asserted during a held load -> next cycle outputs zero, hold_valid=0;
//    a following load uses live rdata

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage, registers EX bus, extends load data, drives WB and forwarding buses
module mem_stage #(
  parameter int EX_TO_MEM_WD = 79,
  parameter int MEM_TO_WB_WD = 70,
  parameter int MEM_TO_RF_WD = 38
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus
);
  logic [EX_TO_MEM_WD-1:0] bus_q, bus_d;
  logic [31:0] rdata_hold_q, rdata_hold_d;
  logic hold_valid_q, hold_valid_d, first_q, first_d;
  logic bubble, is_load, capture;
  logic [31:0] rd, load_data, rf_wdata;
  logic [7:0] lane_b;
  logic [15:0] lane_h;
  logic [2:0] load_op;
  logic [1:0] addr;
  // next state: bubble beats load beats hold; SRAM data is latched only in a load's first, stalled cycle
  always_comb begin
    bubble = stall[3] & ~stall[4];
    is_load = bus_q[46] & (bus_q[45:42] == 4'b0000);
    capture = stall[3] & ~bubble & first_q & is_load;
    bus_d = bubble ? '0 : stall[3] ? bus_q : ex_to_mem_bus;
    hold_valid_d = stall[3] & ~bubble & (hold_valid_q | capture);
    rdata_hold_d = capture ? data_sram_rdata : rdata_hold_q;
    first_d = ~stall[3];
  end
  // pipeline register and read-data hold state
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_q <= '0;
      rdata_hold_q <= '0;
      hold_valid_q <= 1'b0;
      first_q <= 1'b0;
    end else begin
      bus_q <= bus_d;
      rdata_hold_q <= rdata_hold_d;
      hold_valid_q <= hold_valid_d;
      first_q <= first_d;
    end
  end
  // lane select, extension and result mux
  always_comb begin
    addr = bus_q[1:0];
    load_op = bus_q[41:39];
    rd = hold_valid_q ? rdata_hold_q : data_sram_rdata;
    lane_b = rd[{addr, 3'b000} +: 8];
    lane_h = addr[1] ? rd[31:16] : rd[15:0];
    load_data = load_op == 3'b001 ? {{24{lane_b[7]}}, lane_b} :
                load_op == 3'b010 ? {24'b0, lane_b} :
                load_op == 3'b011 ? {{16{lane_h[15]}}, lane_h} :
                load_op == 3'b100 ? {16'b0, lane_h} : rd;
    rf_wdata = bus_q[38] ? load_data : bus_q[31:0];
    mem_to_rf_bus = {bus_q[37], bus_q[36:32], rf_wdata};
    mem_to_wb_bus = {bus_q[78:47], mem_to_rf_bus};
  end
endmodule
